// File: rtl/crc32c_pkg.sv
// Shared constants and state encoding for the CRC-32C (Castagnoli) engine.
package crc32c_pkg;

  localparam logic [31:0] CRC_POLY        = 32'h82F63B78;
  localparam logic [31:0] CRC_INIT        = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_XOROUT      = 32'hFFFFFFFF;
  localparam int          MAX_BYTES_DEF   = 250;
  localparam int          ADDR_W_DEF      = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_FINAL = 3'd4
  } state_e;

endpackage

// File: rtl/crc32c_bit_step.sv
// One reflected CRC-32C bit update; purely combinational so a byte-parallel
// variant can chain eight of these.
module crc32c_bit_step
  import crc32c_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic        bit_in,
  output logic [31:0] crc_out
);

  logic w_fb;

  assign w_fb    = crc_in[0] ^ bit_in;
  assign crc_out = (crc_in >> 1) ^ (w_fb ? CRC_POLY : 32'h0000_0000);

endmodule

// File: rtl/crc32c_engine.sv
// Bit-serial CRC-32C over a byte buffer read through a synchronous port.
// State | meaning: IDLE wait start | FETCH rd_en | LOAD capture byte | SHIFT 8 bits | FINAL publish.
module crc32c_engine
  import crc32c_pkg::*;
#(
  parameter int MAX_BYTES = MAX_BYTES_DEF,
  parameter int ADDR_W    = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] byte_count,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       result
);

  localparam logic [ADDR_W-1:0] LP_MAX = ADDR_W'(MAX_BYTES);

  state_e            r_state;
  logic [31:0]       r_crc;
  logic [31:0]       r_result;
  logic [7:0]        r_shift;
  logic [2:0]        r_bit_cnt;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] r_count;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_rd_en;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  logic [31:0]       w_crc_next;
  logic [ADDR_W-1:0] w_idx_next;

  crc32c_bit_step u_bit_step (
    .crc_in  (r_crc),
    .bit_in  (r_shift[0]),
    .crc_out (w_crc_next)
  );

  assign w_idx_next = r_idx + 1'b1;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state   <= ST_IDLE;
      r_crc     <= CRC_INIT;
      r_result  <= '0;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_idx     <= '0;
      r_count   <= '0;
      r_rd_addr <= '0;
      r_rd_en   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_rd_en <= 1'b0;
      if (abort) begin
        // Cancel wins over everything, including a same-cycle start; err is kept.
        r_state  <= ST_IDLE;
        r_busy   <= 1'b0;
        r_result <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              if (byte_count > LP_MAX) begin
                r_err    <= 1'b1;
                r_result <= '0;
                r_done   <= 1'b1;
              end else begin
                r_err    <= 1'b0;
                r_crc    <= CRC_INIT;
                r_idx    <= '0;
                r_count  <= byte_count;
                r_result <= '0;
                r_busy   <= 1'b1;
                if (byte_count == '0) begin
                  r_state <= ST_FINAL;
                end else begin
                  r_state   <= ST_FETCH;
                  r_rd_en   <= 1'b1;
                  r_rd_addr <= '0;
                end
              end
            end
          end
          ST_FETCH: begin
            r_state <= ST_LOAD;
          end
          ST_LOAD: begin
            r_shift   <= rd_data;
            r_bit_cnt <= '0;
            r_state   <= ST_SHIFT;
          end
          ST_SHIFT: begin
            r_crc     <= w_crc_next;
            r_shift   <= r_shift >> 1;
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              r_idx <= w_idx_next;
              if (w_idx_next == r_count) begin
                r_state <= ST_FINAL;
              end else begin
                r_state   <= ST_FETCH;
                r_rd_en   <= 1'b1;
                r_rd_addr <= w_idx_next;
              end
            end
          end
          ST_FINAL: begin
            r_result <= r_crc ^ CRC_XOROUT;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= ST_IDLE;
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rd_en   = r_rd_en;
  assign rd_addr = r_rd_addr;
  assign busy    = r_busy;
  assign done    = r_done;
  assign err     = r_err;
  assign result  = r_result;

endmodule

// File: doc/crc32c_engine.md
Name: crc32c_engine

Overview:
- Downstream compute stage of the bus-mapped byte-store peripheral (data reg 0x0640, state 0x0648, result 0x0650, control 0x0658).
- On GET, the peripheral hands this engine the stored byte count.
- The engine reads the byte buffer through a synchronous read port and computes CRC-32C (Castagnoli) bit-serially.
- It returns the 32-bit result the peripheral exposes at 0x0650; CLR maps to abort.

Parameters:
- MAX_BYTES, 250: buffer depth; byte_count above this is rejected.
- ADDR_W, 8: buffer address width.

Ports:
- clk  in  1  system clock, rising edge.
- n_reset  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to compute over bytes 0..byte_count-1.
- abort  in  1  cancel current run (CLR).
- byte_count  in  ADDR_W  number of valid bytes in buffer.
- rd_en  out  1  buffer read strobe.
- rd_addr  out  ADDR_W  buffer read address.
- rd_data  in  8  buffer data; valid exactly 1 cycle after the rd_en edge.
- busy  out  1  high from the first cycle after accepted start until done.
- done  out  1  one-cycle pulse, result valid.
- err  out  1  sticky: last start had byte_count > MAX_BYTES.
- result  out  32  CRC-32C, held until next start, abort or reset.

Behaviour:
- Reset (async, n_reset=0): all outputs 0 (busy, done, err, rd_en, rd_addr, result); state IDLE; crc reg 0xFFFFFFFF.
- Algorithm: reflected CRC-32C.
  - poly 0x82F63B78, init 0xFFFFFFFF, xorout 0xFFFFFFFF.
  - Bytes are processed LSB-first.
  - Per bit: fb = crc[0]^d; crc = (crc>>1) ^ (fb ? POLY : 0).
- States:
  - IDLE:
    - start & !abort & byte_count<=MAX_BYTES: clear err, crc<=INIT, idx<=0, busy<=1, go FETCH. If byte_count==0, go FINAL instead.
    - start & byte_count>MAX_BYTES: err<=1, result<=0, done pulse, stay IDLE.
  - FETCH: rd_en=1, rd_addr=idx, go LOAD.
  - LOAD: capture rd_data into shift reg, bit counter<=0, go SHIFT.
  - SHIFT: one bit per cycle for 8 cycles. After bit 7: idx+1; if idx+1==byte_count go FINAL, else FETCH.
  - FINAL: result<=crc^XOROUT, done<=1 for one cycle, busy<=0, go IDLE.
- Latency: 10 cycles per byte.
  - Done is asserted 10*N+2 cycles after the start edge (N=byte_count).
  - N=0: done after 2 cycles, result 0x00000000.
- rd_en is high only in FETCH; rd_addr holds its last value otherwise.
- abort: in any state, next edge → IDLE, busy 0, result 0, no done pulse; err unchanged.
- abort & start in the same cycle: abort wins, start is discarded.
- start while busy: ignored, no effect on the running computation.
- byte_count is sampled only at the accepted start; later changes are ignored.
- Reset mid-run: immediate return to reset values; no done.
- Back-to-back starts after done give identical results over identical data.

Decomposition:
- Package crc32c_pkg holds:
  - localparams CRC_POLY=32'h82F63B78, CRC_INIT=32'hFFFFFFFF, CRC_XOROUT=32'hFFFFFFFF, MAX_BYTES default 250.
  - State encoding: IDLE, FETCH, LOAD, SHIFT, FINAL.
- Sub-module crc32c_bit_step: purely combinational one-bit update (crc_in, bit_in → crc_out). Reused by a future byte-parallel variant.

Test Plan:
- Buffer {AC,DC}, byte_count=2, start → done at cycle 22, result 0x3827E236; rd_addr sequence 0,1; rd_en pulses = 2.
- {53,18,00,80} → 0x A2825413; {00} → 0x527D5351; {00,00,00,00} → 0x48674BC7; 8×0x12 → 0xB2D007FC.
- byte_count=0, start → done 2 cycles later, result 0x00000000, no rd_en.
- 250×0x11 → 0x3C96196E at cycle 2502; 250×0x00 → 0xA51552B8.
- byte_count=251, start → err=1, done pulse, result 0, no rd_en.
- Abort mid-SHIFT, then start on {AC,DC}:
  - During the abort: result=0, no done.
  - Then 0x3827E236.
  - start during busy: ignored.
  - Same-cycle abort+start: stays IDLE.
  - n_reset low mid-run: all outputs 0 immediately.
